// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC select encodings,
// NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BX  = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  // MOV r0, r0
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT,
    F_FLUSH
  } fetch_state_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wdt.sv
// Fetch timeout counter: counts cycles waiting
// for read data; expired marks the last allowed cycle.
module fetch_wdt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Cycle counter, clear wins over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && !clr && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC, single-outstanding
// imem reads, IR latch and redirect/flush handling.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_req,
  input  logic        pc_we,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] bx_target,
  input  logic [31:0] br_target,
  output logic [31:0] IR,
  output logic        W_IR_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_of_ir,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  fetch_state_t state;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        wdt_clr;
  logic        wdt_en;
  logic        wdt_exp;

  assign redir = pc_we &&
    (pc_sel == PC_SEL_BX || pc_sel == PC_SEL_BR);
  assign tgt = word_align(
    (pc_sel == PC_SEL_BX) ? bx_target : br_target);
  assign pc_inc = pc + 32'd4;
  assign imem_addr = pc;

  assign wdt_clr =
    (state == F_REQ && imem_gnt) ||
    (state == F_WAIT && redir && !imem_rvalid);
  assign wdt_en =
    (state == F_WAIT || state == F_FLUSH) && !imem_rvalid;

  fetch_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_exp)
  );

  // Fetch FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= F_IDLE;
      pc         <= RESET_PC;
      IR         <= '0;
      pc_of_ir   <= '0;
      W_IR_valid <= 1'b0;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      W_IR_valid <= 1'b0;
      unique case (state)
        F_IDLE: begin
          if (redir) begin
            pc <= tgt;
          end else if (ir_req) begin
            state      <= F_REQ;
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
          end
        end
        F_REQ: begin
          if (redir) pc <= tgt;
          if (imem_gnt) begin
            state    <= redir ? F_FLUSH : F_WAIT;
            imem_req <= 1'b0;
          end
        end
        F_WAIT: begin
          if (redir) begin
            pc         <= tgt;
            state      <= imem_rvalid ? F_IDLE : F_FLUSH;
            fetch_busy <= !imem_rvalid;
          end else if (imem_rvalid) begin
            IR         <= imem_rdata;
            pc_of_ir   <= pc;
            pc         <= pc_inc;
            W_IR_valid <= 1'b1;
            state      <= F_IDLE;
            fetch_busy <= 1'b0;
          end else if (wdt_exp) begin
            fetch_err  <= 1'b1;
            IR         <= NOP_INSTR;
            pc_of_ir   <= pc;
            pc         <= pc_inc;
            W_IR_valid <= 1'b1;
            state      <= F_IDLE;
            fetch_busy <= 1'b0;
          end
        end
        F_FLUSH: begin
          if (redir) pc <= tgt;
          if (imem_rvalid) begin
            state      <= F_IDLE;
            fetch_busy <= 1'b0;
          end else if (wdt_exp) begin
            fetch_err  <= 1'b1;
            state      <= F_IDLE;
            fetch_busy <= 1'b0;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch.
// Main DUT default timeout, second DUT TIMEOUT=4.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] RPC_B = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_req = 1'b0;
  logic        pc_we = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] bx_target = '0;
  logic [31:0] br_target = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic [31:0] a_ir, a_pc, a_poi, a_addr;
  logic        a_v, a_busy, a_err, a_req;
  logic [31:0] b_ir, b_pc, b_poi, b_addr;
  logic        b_v, b_busy, b_err, b_req;

  always #5 clk = ~clk;

  instr_fetch dut_a (
    .clk(clk), .rst(rst), .ir_req(ir_req),
    .pc_we(pc_we), .pc_sel(pc_sel),
    .bx_target(bx_target), .br_target(br_target),
    .IR(a_ir), .W_IR_valid(a_v), .pc(a_pc),
    .pc_of_ir(a_poi), .fetch_busy(a_busy),
    .fetch_err(a_err), .imem_req(a_req),
    .imem_addr(a_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  instr_fetch #(.RESET_PC(RPC_B), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .ir_req(ir_req),
    .pc_we(pc_we), .pc_sel(pc_sel),
    .bx_target(bx_target), .br_target(br_target),
    .IR(b_ir), .W_IR_valid(b_v), .pc(b_pc),
    .pc_of_ir(b_poi), .fetch_busy(b_busy),
    .fetch_err(b_err), .imem_req(b_req),
    .imem_addr(b_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] poi;
    logic [31:0] addr;
    logic        busy;
    logic        req;
    logic        err;
  } out_t;

  typedef struct {
    logic        ir_req;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] bx;
    logic [31:0] br;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nmis = 0;

  function automatic out_t mk(
    input logic v, input logic [31:0] ir,
    input logic [31:0] p, input logic [31:0] poi,
    input logic busy, input logic req, input logic err
  );
    out_t o;
    o.v = v; o.ir = ir; o.pc = p; o.poi = poi;
    o.addr = p; o.busy = busy; o.req = req; o.err = err;
    return o;
  endfunction

  function automatic void add(
    input logic ir, input logic we, input logic [1:0] sel,
    input logic [31:0] bx, input logic [31:0] br,
    input logic g, input logic rv, input logic [31:0] rd,
    input out_t e
  );
    vec_t t;
    t.ir_req = ir; t.we = we; t.sel = sel;
    t.bx = bx; t.br = br; t.g = g; t.rv = rv;
    t.rd = rd; t.exp = e;
    tbl.push_back(t);
  endfunction

  function automatic out_t act_a();
    return '{a_v, a_ir, a_pc, a_poi, a_addr,
             a_busy, a_req, a_err};
  endfunction

  function automatic out_t act_b();
    return '{b_v, b_ir, b_pc, b_poi, b_addr,
             b_busy, b_req, b_err};
  endfunction

  task automatic chk(input string nm, input out_t act,
                     input out_t exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic ir, input logic we, input logic [1:0] sel,
    input logic [31:0] bx, input logic [31:0] br,
    input logic g, input logic rv, input logic [31:0] rd
  );
    ir_req = ir; pc_we = we; pc_sel = sel;
    bx_target = bx; br_target = br;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // sequential fetch, zero wait
    add(1,0,0,0,0,0,0,0, mk(0,0,0,0,1,1,0));
    add(1,0,0,0,0,1,0,0, mk(0,0,0,0,1,0,0));
    add(1,0,0,0,0,0,1,0, mk(1,0,4,0,0,0,0));
    add(1,0,0,0,0,0,0,0, mk(0,0,4,0,1,1,0));
    add(1,0,0,0,0,1,0,0, mk(0,0,4,0,1,0,0));
    add(1,0,0,0,0,0,1,4, mk(1,4,8,4,0,0,0));
    add(1,0,0,0,0,0,0,0, mk(0,4,8,4,1,1,0));
    add(1,0,0,0,0,1,0,0, mk(0,4,8,4,1,0,0));
    add(1,0,0,0,0,0,1,8, mk(1,8,12,8,0,0,0));
    // grant +2, rvalid +5
    add(1,0,0,0,0,0,0,0, mk(0,8,12,8,1,1,0));
    add(1,0,0,0,0,0,0,0, mk(0,8,12,8,1,1,0));
    add(1,0,0,0,0,0,0,0, mk(0,8,12,8,1,1,0));
    add(1,0,0,0,0,1,0,0, mk(0,8,12,8,1,0,0));
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0,0,0,0, mk(0,8,12,8,1,0,0));
    add(0,0,0,0,0,0,1,'hC, mk(1,12,16,12,0,0,0));
    // redirect in WAIT
    add(1,0,0,0,0,0,0,0, mk(0,12,16,12,1,1,0));
    add(0,0,0,0,0,1,0,0, mk(0,12,16,12,1,0,0));
    add(0,1,2'b10,'h5555,'h100,0,0,0,
        mk(0,12,'h100,12,1,0,0));
    add(0,0,0,0,0,0,1,'hDEAD, mk(0,12,'h100,12,0,0,0));
    add(1,0,0,0,0,0,0,0, mk(0,12,'h100,12,1,1,0));
    add(0,0,0,0,0,1,0,0, mk(0,12,'h100,12,1,0,0));
    add(0,0,0,0,0,0,1,'h100,
        mk(1,'h100,'h104,'h100,0,0,0));
    // BX alignment in IDLE, ignored selects
    add(1,1,2'b01,'h2003,'h7777,0,0,0,
        mk(0,'h100,'h2000,'h100,0,0,0));
    add(1,1,2'b11,'h3000,'h4000,0,0,0,
        mk(0,'h100,'h2000,'h100,1,1,0));
    add(0,1,2'b00,'h3000,'h4000,0,0,0,
        mk(0,'h100,'h2000,'h100,1,1,0));
    // redirect in REQ, then with grant
    add(0,1,2'b10,0,'h3000,0,0,0,
        mk(0,'h100,'h3000,'h100,1,1,0));
    add(0,1,2'b01,'h4001,0,1,0,0,
        mk(0,'h100,'h4000,'h100,1,0,0));
    add(0,1,2'b10,0,'h5000,0,0,0,
        mk(0,'h100,'h5000,'h100,1,0,0));
    add(0,0,0,0,0,0,1,'hBAD,
        mk(0,'h100,'h5000,'h100,0,0,0));
    // stray rvalid in IDLE and REQ
    add(0,0,0,0,0,0,1,'hBAD,
        mk(0,'h100,'h5000,'h100,0,0,0));
    add(1,0,0,0,0,0,0,0, mk(0,'h100,'h5000,'h100,1,1,0));
    add(1,0,0,0,0,0,1,'hBAD,
        mk(0,'h100,'h5000,'h100,1,1,0));
    add(0,0,0,0,0,1,0,0, mk(0,'h100,'h5000,'h100,1,0,0));
    // redirect with rvalid in WAIT
    add(0,1,2'b10,0,'h6000,0,1,'hBAD,
        mk(0,'h100,'h6000,'h100,0,0,0));
    add(1,0,0,0,0,0,0,0, mk(0,'h100,'h6000,'h100,1,1,0));
    add(0,0,0,0,0,1,0,0, mk(0,'h100,'h6000,'h100,1,0,0));
    add(0,0,0,0,0,0,1,'h600A,
        mk(1,'h600A,'h6004,'h6000,0,0,0));
    // PC wrap
    add(0,1,2'b10,0,'hFFFF_FFFF,0,0,0,
        mk(0,'h600A,'hFFFF_FFFC,'h6000,0,0,0));
    add(1,0,0,0,0,0,0,0,
        mk(0,'h600A,'hFFFF_FFFC,'h6000,1,1,0));
    add(0,0,0,0,0,1,0,0,
        mk(0,'h600A,'hFFFF_FFFC,'h6000,1,0,0));
    add(0,0,0,0,0,0,1,'h11,
        mk(1,'h11,0,'hFFFF_FFFC,0,0,0));

    // reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", act_a(), mk(0,0,0,0,0,0,0));
    chk("reset_b", act_b(), mk(0,0,RPC_B,0,0,0,0));
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ir_req, tbl[i].we, tbl[i].sel,
            tbl[i].bx, tbl[i].br, tbl[i].g,
            tbl[i].rv, tbl[i].rd);
      chk($sformatf("vec%0d", i), act_a(), tbl[i].exp);
    end

    // reset mid-WAIT
    drive(1,0,0,0,0,0,0,0);
    chk("mw_req", act_a(), mk(0,'h11,0,'hFFFF_FFFC,1,1,0));
    drive(0,0,0,0,0,1,0,0);
    chk("mw_wait", act_a(), mk(0,'h11,0,'hFFFF_FFFC,1,0,0));
    #3;
    rst = 1'b0;
    #1;
    chk("mw_rst", act_a(), mk(0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0,0,0,0,0,0,1,'hBEEF);
    chk("mw_late_rv", act_a(), mk(0,0,0,0,0,0,0));
    chk("mw_b", act_b(), mk(0,0,RPC_B,0,0,0,0));

    // timeout on TIMEOUT=4 instance
    drive(1,0,0,0,0,0,0,0);
    chk("to_req", act_b(), mk(0,0,RPC_B,0,1,1,0));
    drive(0,0,0,0,0,1,0,0);
    chk("to_gnt", act_b(), mk(0,0,RPC_B,0,1,0,0));
    for (int k = 0; k < 3; k++) begin
      idle1();
      chk($sformatf("to_wait%0d", k), act_b(),
          mk(0,0,RPC_B,0,1,0,0));
    end
    idle1();
    chk("to_fire", act_b(), mk(1,NOP,RPC_B+4,RPC_B,0,0,1));
    idle1();
    chk("to_after", act_b(), mk(0,NOP,RPC_B+4,RPC_B,0,0,1));
    drive(0,0,0,0,0,0,1,'h1234);
    chk("to_stray", act_b(), mk(0,NOP,RPC_B+4,RPC_B,0,0,1));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit feeding the multi-cycle ARM control FSM. It owns the program counter and issues single-outstanding word reads to instruction memory. It latches the returned word into IR and signals the controller with a one-cycle `W_IR_valid` pulse. It also applies PC redirects from the controller (BX and B/BL targets) and flushes any in-flight fetch made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT`, default 64: maximum cycles from grant to `imem_rvalid` before a fetch fault is declared.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ir_req` in 1: controller wants the next instruction; level-sensitive.
- `pc_we` in 1: redirect strobe from the controller.
- `pc_sel` in 2: redirect source; 01 = `bx_target`, 10 = `br_target`; 00 and 11 are ignored.
- `bx_target` in 32: register-file Rm value for BX.
- `br_target` in 32: ALU result F for B/BL.
- `IR` out 32: current instruction; stable between pulses.
- `W_IR_valid` out 1: one-cycle pulse when IR is updated.
- `pc` out 32: address of the next fetch.
- `pc_of_ir` out 32: address of the word currently in IR.
- `fetch_busy` out 1: high in REQ, WAIT and FLUSH.
- `fetch_err` out 1: sticky timeout flag, cleared only by reset.
- `imem_req` out 1: memory request; held until granted.
- `imem_addr` out 32: request address; equals `pc` while `imem_req` is high.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid; at most one per grant.
- `imem_rdata` in 32: read data.

## Operation
- States:
  - IDLE: no memory transaction.
  - REQ: `imem_req` is asserted.
  - WAIT: granted, data pending.
  - FLUSH: granted, data will be discarded.
- Transitions:
  - IDLE → REQ when `ir_req` is high and no redirect arrives that cycle. A redirect in IDLE updates PC and the state stays IDLE.
  - REQ → WAIT on `imem_gnt`.
  - REQ with redirect and no grant: PC updates and the state stays in REQ. `imem_addr` follows the new PC. This is the only case where the address may change under an ungranted request.
  - REQ with redirect and `imem_gnt` in the same cycle: PC updates and the state goes to FLUSH.
  - WAIT on `imem_rvalid` with no redirect: IR ← `imem_rdata`, `pc_of_ir` ← PC, PC ← PC+4, pulse `W_IR_valid`, → IDLE.
  - WAIT with redirect and no `imem_rvalid`: PC ← target, → FLUSH.
  - WAIT with redirect and `imem_rvalid` in the same cycle: the data is discarded, PC ← target, no pulse, → IDLE.
  - FLUSH on `imem_rvalid`: the data is dropped and the state goes to IDLE. A redirect in FLUSH updates PC and the state stays in FLUSH.
- Redirect target is `{target[31:2], 2'b00}`. The low two bits are always cleared, so the BX Thumb bit is ignored.
- PC arithmetic is 32-bit unsigned modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Timeout counter:
  - Cleared on entry to WAIT or FLUSH.
  - Increments each cycle in WAIT or FLUSH without `imem_rvalid`.
  - Reaching `TIMEOUT` in WAIT: set `fetch_err`, IR ← NOP (32'hE1A0_0000), `pc_of_ir` ← PC, PC ← PC+4, pulse `W_IR_valid`, → IDLE.
  - Reaching `TIMEOUT` in FLUSH: set `fetch_err` and go to IDLE with no pulse.
- `imem_rvalid` arriving in IDLE or REQ is ignored. This covers a late response after reset or after a timeout.
- Reset state:
  - State is IDLE.
  - `pc` = `RESET_PC`.
  - `IR`, `pc_of_ir` and the timeout counter are 0.
  - `W_IR_valid`, `fetch_busy`, `fetch_err` and `imem_req` are 0.
- Reset asserted mid-transaction aborts immediately. No pulse is generated.

## Timing
- All outputs are registered except `imem_addr`, which is a direct copy of the PC register.
- Minimum latency:
  - `ir_req` seen at cycle 0 → `imem_req` high at cycle 1.
  - Grant at 1 and `imem_rvalid` at 2 → `W_IR_valid` and new IR at cycle 3.
- Back-to-back: holding `ir_req` high gives one instruction every 3 cycles at zero memory wait.
- `W_IR_valid` is exactly one cycle wide. IR is unchanged until the next pulse.
- Redirect takes effect on the next edge; `pc` shows the target one cycle after `pc_we`.
- `pc_we` with `pc_sel` 00 or 11 has no effect on PC or on the state.

## Structure
- Put the following in the shared `cpu_pkg`:
  - `PC_SEL_SEQ`/`PC_SEL_BX`/`PC_SEL_BR` (00/01/10) constants, so the controller and this block use the same encodings.
  - The NOP encoding constant.
  - The fetch-state enum.
- One natural sub-module, `fetch_wdt`: the timeout counter.
  - Inputs: clear, count enable.
  - Output: `expired`.
  - Parameterised by `TIMEOUT`.

## Test plan
- Sequential fetch: reset, `ir_req` held high, memory grants immediately with data = address.
  - Pulses at cycles 3, 6 and 9.
  - IR = 0, 4, 8; `pc` = 4, 8, 12.
- Wait states: grant delayed 2 cycles, `imem_rvalid` delayed 5 cycles → the pulse appears 7 cycles after the zero-wait position, and `imem_addr` is stable throughout REQ.
- Redirect in WAIT: `pc_we` with `pc_sel`=10 and `br_target`=32'h100 while WAIT.
  - The stale data is dropped.
  - The next pulse has IR from 32'h100 and `pc_of_ir`=32'h100.
- BX alignment: `bx_target`=32'h0000_2003, `pc_sel`=01 → `pc`=32'h2000.
- Timeout: `TIMEOUT`=4, `imem_rvalid` never returns after grant.
  - Pulse with IR=32'hE1A0_0000 and `fetch_err`=1.
  - A later stray `imem_rvalid` is ignored.
- Reset mid-WAIT: `rst` low for 1 cycle → `pc`=`RESET_PC`, state IDLE, no pulse; the subsequent `imem_rvalid` is ignored.
